// File: rtl/sys_pio_pwm_if.sv
// -----------------------------------------------------------------------------
// sys_pio_pwm_if
// Connects the PIO output word to the PWM generator and carries its status
// back to the master.
//   cfg_word    : 32-bit PIO output word (master -> slave)
//   pwm_out     : registered PWM output (slave -> master)
//   period_tick : one-cycle pulse when a PWM period completes (slave -> master)
//   active      : 1 while the generator is running (slave -> master)
// -----------------------------------------------------------------------------
interface sys_pio_pwm_if;
    logic [31:0] cfg_word;
    logic        pwm_out;
    logic        period_tick;
    logic        active;

    modport master (
        output cfg_word,
        input  pwm_out,
        input  period_tick,
        input  active
    );

    modport slave (
        input  cfg_word,
        output pwm_out,
        output period_tick,
        output active
    );
endinterface

// File: rtl/sys_pio_pwm.sv
// -----------------------------------------------------------------------------
// sys_pio_pwm
// Turns the 32-bit PIO output word into one glitch-free PWM output for ECU
// actuators. The word is decoded as:
//   [31]    en      enable
//   [30:16] period  period length in ticks
//   [15]    pol     0 = active-high, 1 = active-low
//   [14:0]  duty    active time in ticks
// A tick is PRESCALE clk cycles. New settings are captured into shadow
// registers only at a period end, so writes through the PIO never cut or
// stretch a pulse.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of sys_pio_pwm_if (cfg_word in; pwm_out,
//              period_tick, active out)
// -----------------------------------------------------------------------------
module sys_pio_pwm #(
    parameter int PRESCALE   = 50,
    parameter int PRESCALE_W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    sys_pio_pwm_if.slave   bus
);

    localparam logic [PRESCALE_W-1:0] PSC_MAX = PRESCALE_W'(PRESCALE - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [PRESCALE_W-1:0] r_psc;
    logic [14:0]           r_cnt;
    logic [14:0]           r_period_s;
    logic [14:0]           r_duty_s;
    logic                  r_pol_s;
    logic                  r_pwm;
    logic                  r_tick;

    // Live decode of the PIO word
    logic                  w_en;
    logic [14:0]           w_period;
    logic                  w_pol;
    logic [14:0]           w_duty;
    logic                  w_start_ok;

    logic                  w_psc_tick;
    logic                  w_last_tick;
    logic                  w_period_end;
    logic                  w_load;

    assign w_en       = bus.cfg_word[31];
    assign w_period   = bus.cfg_word[30:16];
    assign w_pol      = bus.cfg_word[15];
    assign w_duty     = bus.cfg_word[14:0];
    // A zero period is not a runnable command; treat it like en=0.
    assign w_start_ok = w_en && (w_period != 15'd0);

    assign w_psc_tick   = (r_psc == PSC_MAX);
    // period_s is never 0 while running, so period_s-1 does not underflow.
    assign w_last_tick  = (r_cnt == (r_period_s - 15'd1));
    assign w_period_end = (r_state == S_RUN) && w_psc_tick && w_last_tick;
    // Shadows are captured on entry to RUN and at every period end.
    assign w_load       = ((r_state == S_IDLE) && w_start_ok) || w_period_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // The running period always completes before leaving RUN.
                if (w_period_end && !w_start_ok) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_psc      <= '0;
            r_cnt      <= '0;
            r_period_s <= '0;
            r_duty_s   <= '0;
            r_pol_s    <= 1'b0;
            r_pwm      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            if (r_state == S_RUN) begin
                r_psc <= w_psc_tick ? '0 : (r_psc + PRESCALE_W'(1));
                if (w_psc_tick) begin
                    r_cnt <= w_last_tick ? 15'd0 : (r_cnt + 15'd1);
                end
                // duty_s >= period_s keeps the compare true for every count,
                // giving a constant active level with no gap.
                r_pwm <= (r_cnt < r_duty_s) ^ r_pol_s;
            end else begin
                r_psc <= '0;
                r_cnt <= '0;
                // Idle output follows the live polarity (inactive level).
                r_pwm <= w_pol;
            end

            if (w_load) begin
                r_period_s <= w_period;
                r_duty_s   <= w_duty;
                r_pol_s    <= w_pol;
            end

            r_tick <= w_period_end;
        end
    end

    assign bus.pwm_out     = r_pwm;
    assign bus.period_tick = r_tick;
    assign bus.active      = (r_state == S_RUN);

endmodule

// File: tb/tb_sys_pio_pwm.sv
module tb_sys_pio_pwm;

    localparam int P = 3;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    sys_pio_pwm_if bus ();
    sys_pio_pwm_if bus1 ();

    sys_pio_pwm #(.PRESCALE(P), .PRESCALE_W(16)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    sys_pio_pwm #(.PRESCALE(1), .PRESCALE_W(16)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ------------------------------------------------------------------
    // Reference model for u_dut: tracks the time elapsed since the start of
    // the current period and derives the tick count as elapsed / P.
    // ------------------------------------------------------------------
    int   cyc;
    bit   m_run;
    int   m_start;
    int   m_per;
    int   m_duty;
    bit   m_pol;
    logic e_pwm, e_tick, e_act;

    logic c_en, c_pol;
    int   c_per, c_duty, m_elapsed;

    assign c_en      = bus.cfg_word[31];
    assign c_pol     = bus.cfg_word[15];
    assign c_per     = int'(bus.cfg_word[30:16]);
    assign c_duty    = int'(bus.cfg_word[14:0]);
    assign m_elapsed = cyc - m_start;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc     <= 0;
            m_run   <= 1'b0;
            m_start <= 0;
            e_pwm   <= 1'b0;
            e_tick  <= 1'b0;
            e_act   <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (!m_run) begin
                e_pwm  <= c_pol;
                e_tick <= 1'b0;
                if (c_en && c_per != 0) begin
                    m_run   <= 1'b1;
                    e_act   <= 1'b1;
                    m_per   <= c_per;
                    m_duty  <= c_duty;
                    m_pol   <= c_pol;
                    m_start <= cyc + 1;
                end
            end else begin
                e_pwm <= ((m_elapsed / P) < m_duty) ^ m_pol;
                if (m_elapsed == m_per * P - 1) begin
                    e_tick  <= 1'b1;
                    m_per   <= c_per;
                    m_duty  <= c_duty;
                    m_pol   <= c_pol;
                    m_start <= cyc + 1;
                    if (!(c_en && c_per != 0)) begin
                        m_run <= 1'b0;
                        e_act <= 1'b0;
                    end
                end else begin
                    e_tick <= 1'b0;
                end
            end
        end
    end

    function automatic logic [31:0] mk_cfg(input logic en, input int per,
                                           input logic pol, input int duty);
        return {en, per[14:0], pol, duty[14:0]};
    endfunction

    task automatic go_idle();
        bus.cfg_word = 32'h0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.active === 1'b0) break;
        end
        n_cmp++;
        if (bus.active !== 1'b0) begin
            n_fail++;
            $display("FAIL go_idle_timeout active=%b required=0", bus.active);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.cfg_word  = 32'h0;
        bus1.cfg_word = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.pwm_out, bus.period_tick, bus.active} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b required=000",
                     {bus.pwm_out, bus.period_tick, bus.active});
        end
        n_cmp++;
        if ({bus1.pwm_out, bus1.period_tick, bus1.active} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs_p1 got=%b required=000",
                     {bus1.pwm_out, bus1.period_tick, bus1.active});
        end
        reset_n = 1'b1;
        // pol applies immediately in IDLE, with one register of latency
        bus.cfg_word = mk_cfg(1'b0, 0, 1'b1, 0);
        @(negedge clk);
        n_cmp++;
        if ({bus.pwm_out, bus.active} !== 2'b10) begin
            n_fail++;
            $display("FAIL idle_pol got pwm/act=%b required=10", {bus.pwm_out, bus.active});
        end
        bus.cfg_word = 32'h0;
        @(negedge clk);
        n_cmp++;
        if ({bus.pwm_out, bus.period_tick, bus.active} !== {e_pwm, e_tick, e_act}) begin
            n_fail++;
            $display("FAIL idle_model got=%b required=%b",
                     {bus.pwm_out, bus.period_tick, bus.active}, {e_pwm, e_tick, e_act});
        end
    endtask

    task automatic test_prescale1();
        bus1.cfg_word = 32'h8004_0001;
        @(negedge clk);
        n_cmp++;
        if ({bus1.active, bus1.pwm_out} !== 2'b10) begin
            n_fail++;
            $display("FAIL p1_entry got act/pwm=%b required=10", {bus1.active, bus1.pwm_out});
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus1.pwm_out, bus1.period_tick, bus1.active} !==
                {(k % 4 == 0), (k % 4 == 3), 1'b1}) begin
                n_fail++;
                $display("FAIL p1_pattern k=%0d got=%b required=%b", k,
                         {bus1.pwm_out, bus1.period_tick, bus1.active},
                         {(k % 4 == 0), (k % 4 == 3), 1'b1});
            end
        end
        bus1.cfg_word = 32'h0;
    endtask

    task automatic test_prescale3();
        int first_tick = 0;
        int second_tick = 0;
        int hi = 0;
        go_idle();
        bus.cfg_word = mk_cfg(1'b1, 5, 1'b0, 2);
        for (int s = 1; s <= 75; s++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.pwm_out, bus.period_tick, bus.active} !== {e_pwm, e_tick, e_act}) begin
                n_fail++;
                $display("FAIL p3_model s=%0d got=%b required=%b", s,
                         {bus.pwm_out, bus.period_tick, bus.active}, {e_pwm, e_tick, e_act});
            end
            if (first_tick != 0 && second_tick == 0) hi += int'(bus.pwm_out);
            if (bus.period_tick === 1'b1) begin
                if (first_tick == 0) first_tick = s;
                else if (second_tick == 0) second_tick = s;
            end
        end
        n_cmp++;
        if (first_tick != 16) begin
            n_fail++;
            $display("FAIL p3_first_tick got=%0d required=16", first_tick);
        end
        n_cmp++;
        if (second_tick - first_tick != 15) begin
            n_fail++;
            $display("FAIL p3_tick_spacing got=%0d required=15", second_tick - first_tick);
        end
        n_cmp++;
        if (hi != 6) begin
            n_fail++;
            $display("FAIL p3_high_cycles got=%0d required=6", hi);
        end
    endtask

    task automatic test_midchange();
        int hi = 0;
        int np = 0;
        int per_hi [4] = '{0, 0, 0, 0};
        go_idle();
        bus.cfg_word = mk_cfg(1'b1, 8, 1'b0, 2);
        for (int s = 1; s <= 60; s++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.pwm_out, bus.period_tick, bus.active} !== {e_pwm, e_tick, e_act}) begin
                n_fail++;
                $display("FAIL mid_model s=%0d got=%b required=%b", s,
                         {bus.pwm_out, bus.period_tick, bus.active}, {e_pwm, e_tick, e_act});
            end
            hi += int'(bus.pwm_out);
            if (bus.period_tick === 1'b1 && np < 4) begin
                per_hi[np] = hi;
                np++;
                hi = 0;
            end
            if (s == 10) bus.cfg_word = mk_cfg(1'b1, 8, 1'b0, 6);
        end
        n_cmp++;
        if (per_hi[0] != 6) begin
            n_fail++;
            $display("FAIL mid_first_period_high got=%0d required=6", per_hi[0]);
        end
        n_cmp++;
        if (per_hi[1] != 18) begin
            n_fail++;
            $display("FAIL mid_second_period_high got=%0d required=18", per_hi[1]);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] cfgs [4];
        cfgs[0] = mk_cfg(1'b1, 4, 1'b0, 0);
        cfgs[1] = mk_cfg(1'b1, 4, 1'b0, 4);
        cfgs[2] = mk_cfg(1'b1, 4, 1'b0, 32'h7FFF);
        cfgs[3] = mk_cfg(1'b1, 4, 1'b1, 1);
        for (int c = 0; c < 4; c++) begin
            int bad = 0;
            int hi = 0;
            logic first_val = 1'bx;
            go_idle();
            bus.cfg_word = cfgs[c];
            for (int s = 1; s <= 48; s++) begin
                @(negedge clk);
                n_cmp++;
                if ({bus.pwm_out, bus.period_tick, bus.active} !== {e_pwm, e_tick, e_act}) begin
                    n_fail++;
                    $display("FAIL bnd_model case=%0d s=%0d got=%b required=%b", c, s,
                             {bus.pwm_out, bus.period_tick, bus.active}, {e_pwm, e_tick, e_act});
                end
                if (s >= 2) begin
                    if (c == 0 && bus.pwm_out !== 1'b0) bad++;
                    if ((c == 1 || c == 2) && bus.pwm_out !== 1'b1) bad++;
                end
                if (s == 2) first_val = bus.pwm_out;
                if (s >= 2 && s <= 13) hi += int'(bus.pwm_out);
            end
            if (c < 3) begin
                n_cmp++;
                if (bad != 0) begin
                    n_fail++;
                    $display("FAIL bnd_constant case=%0d off_level_cycles=%0d required=0", c, bad);
                end
            end else begin
                n_cmp++;
                if (hi != 9 || first_val !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bnd_pol_low high=%0d first=%b required high=9 first=0",
                             hi, first_val);
                end
            end
        end
    endtask

    task automatic test_disable();
        int ticks = 0;
        int tick_at = 0;
        int drop_at = 0;
        int act_bad = 0;
        logic pwm20 = 1'bx;
        go_idle();
        bus.cfg_word = mk_cfg(1'b1, 6, 1'b0, 3);
        for (int s = 1; s <= 30; s++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.pwm_out, bus.period_tick, bus.active} !== {e_pwm, e_tick, e_act}) begin
                n_fail++;
                $display("FAIL dis_model s=%0d got=%b required=%b", s,
                         {bus.pwm_out, bus.period_tick, bus.active}, {e_pwm, e_tick, e_act});
            end
            if (bus.period_tick === 1'b1) begin
                ticks++;
                if (tick_at == 0) tick_at = s;
            end
            if (bus.active === 1'b0 && drop_at == 0) drop_at = s;
            if (s == 20) pwm20 = bus.pwm_out;
            if (s == 4) bus.cfg_word = mk_cfg(1'b0, 6, 1'b1, 3);
        end
        n_cmp++;
        if (tick_at != 19 || ticks != 1) begin
            n_fail++;
            $display("FAIL dis_tick at=%0d count=%0d required at=19 count=1", tick_at, ticks);
        end
        n_cmp++;
        if (drop_at != 19) begin
            n_fail++;
            $display("FAIL dis_active_drop got=%0d required=19", drop_at);
        end
        n_cmp++;
        if (pwm20 !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_pol_level got=%b required=1", pwm20);
        end
        bus.cfg_word = 32'h8000_0005;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            if (bus.active !== 1'b0 || bus.period_tick !== 1'b0) act_bad++;
        end
        n_cmp++;
        if (act_bad != 0) begin
            n_fail++;
            $display("FAIL dis_zero_period running_cycles=%0d required=0", act_bad);
        end
    endtask

    task automatic test_async_reset();
        int tick_at = 0;
        go_idle();
        bus.cfg_word = mk_cfg(1'b1, 8, 1'b0, 4);
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.pwm_out, bus.period_tick, bus.active} !== {e_pwm, e_tick, e_act}) begin
                n_fail++;
                $display("FAIL ar_pre_model s=%0d got=%b required=%b", s,
                         {bus.pwm_out, bus.period_tick, bus.active}, {e_pwm, e_tick, e_act});
            end
        end
        n_cmp++;
        if (bus.pwm_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_pre_high got=%b required=1", bus.pwm_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.pwm_out, bus.period_tick, bus.active} !== 3'b000) begin
            n_fail++;
            $display("FAIL ar_immediate got=%b required=000",
                     {bus.pwm_out, bus.period_tick, bus.active});
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.pwm_out, bus.period_tick, bus.active} !== 3'b000) begin
            n_fail++;
            $display("FAIL ar_held got=%b required=000",
                     {bus.pwm_out, bus.period_tick, bus.active});
        end
        reset_n = 1'b1;
        for (int s = 1; s <= 30; s++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.pwm_out, bus.period_tick, bus.active} !== {e_pwm, e_tick, e_act}) begin
                n_fail++;
                $display("FAIL ar_post_model s=%0d got=%b required=%b", s,
                         {bus.pwm_out, bus.period_tick, bus.active}, {e_pwm, e_tick, e_act});
            end
            if (s == 2) begin
                n_cmp++;
                if ({bus.active, bus.pwm_out} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL ar_restart got act/pwm=%b required=11",
                             {bus.active, bus.pwm_out});
                end
            end
            if (bus.period_tick === 1'b1 && tick_at == 0) tick_at = s;
        end
        n_cmp++;
        if (tick_at != 25) begin
            n_fail++;
            $display("FAIL ar_first_tick got=%0d required=25", tick_at);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.pwm_out, bus.period_tick, bus.active} !== {e_pwm, e_tick, e_act}) begin
                n_fail++;
                $display("FAIL rnd_model c=%0d cfg=%h got=%b required=%b", c, bus.cfg_word,
                         {bus.pwm_out, bus.period_tick, bus.active}, {e_pwm, e_tick, e_act});
            end
            if (hold == 0) begin
                logic en;
                logic pol;
                int   per;
                int   duty;
                en   = ($urandom_range(0, 9) != 0);
                per  = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
                pol  = 1'($urandom_range(0, 1));
                duty = ($urandom_range(0, 19) == 0) ? 32'h7FFF : int'($urandom_range(0, 8));
                bus.cfg_word = mk_cfg(en, per, pol, duty);
                hold = int'($urandom_range(1, 25));
            end else begin
                hold--;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_prescale1();
        test_prescale3();
        test_midchange();
        test_boundary();
        test_disable();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_pio_pwm.md
Name: sys_pio_pwm

Overview:
Downstream consumer of the 32-bit PIO output word (out_port of the Avalon PIO output register). Interprets the word as a PWM control command and generates one glitch-free PWM output for ECU actuators such as injector or valve drivers. New settings take effect only at period boundaries, so software writes through the PIO never produce runt pulses.

Parameters:
PRESCALE, 50, clk cycles per PWM tick (50 MHz clk gives a 1 us tick); legal range 1..65535
PRESCALE_W, 16, width of the prescaler counter; must hold PRESCALE-1

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous and active-low
cfg_word  in  32  PIO output word, same clock domain, no synchroniser
pwm_out  out  1  registered PWM output
period_tick  out  1  one-cycle pulse at each completed PWM period
active  out  1  1 while the state machine is in RUN

Behaviour:
Field decode of cfg_word:
- en = [31]
- period = [30:16], 15 bits, in ticks
- pol = [15]; 0 = active-high, 1 = active-low
- duty = [14:0], in ticks

Reset (asynchronous, reset_n=0):
- State goes to IDLE immediately.
- Prescaler, period counter cnt, and shadow registers (period_s, duty_s, pol_s) clear to 0.
- pwm_out=0, period_tick=0, active=0.
- Asserting reset mid-period aborts the period at once; no completion.

IDLE:
- Prescaler and cnt are held at 0.
- active=0.
- pwm_out = live pol (inactive level), registered, so 1-cycle latency.
- Transition to RUN on the first clk edge where en=1 and period!=0. At that edge, load period_s/duty_s/pol_s from cfg_word and set cnt=0, prescaler=0.
- en=1 with period=0 is ignored; the block stays in IDLE.

RUN:
- active=1.
- Prescaler counts 0..PRESCALE-1 and wraps. A tick is the cycle where prescaler==PRESCALE-1. PRESCALE=1 gives a tick every cycle.
- On a tick with cnt != period_s-1: cnt increments.
- On a tick with cnt == period_s-1 (period end):
  - cnt <= 0.
  - period_tick asserts for exactly one cycle at the next clk edge.
  - Shadows reload from the live cfg_word.
  - If live en=0 or live period=0, go to IDLE instead. The current period always completes; there is no truncation.
- Output: pwm_out <= ((cnt < duty_s) XOR pol_s), registered one cycle after cnt.
  - duty_s=0: constant inactive level.
  - duty_s >= period_s: constant active level, with no inactive gap.
- cfg_word changes mid-period have no effect until the period end; only the value present on the period-end cycle is used.
- Period length is exactly period_s*PRESCALE clk cycles. Maximum is 32767 ticks; no wrap beyond period_s-1.

Simultaneous events:
- A period end coinciding with en falling: the period completes and the block goes to IDLE. period_tick still pulses.
- Changes to pol apply at the period end, or immediately in IDLE.

Arithmetic:
- All compares are unsigned 15-bit.
- The prescaler compare uses PRESCALE_W bits.

Test Plan:
1. Reset, then PRESCALE=1, cfg=0x8004_0001 (en, period=4, duty=1) -> pwm_out repeats 1,0,0,0 (1 high cycle in 4); period_tick every 4 clk; active=1.
2. PRESCALE=3, period=5, duty=2 -> high 6 clk, low 9 clk; period_tick every 15 clk.
3. Running period=8 duty=2; change cfg to duty=6 at cnt=3 -> current period still ends after 2 high ticks; the next period shows 6 high ticks; no runt or extended pulse.
4. Boundary duties: duty=0 -> pwm_out constantly 0; duty=period=4 and duty=0x7FFF -> pwm_out constantly 1; pol=1 with duty=1 period=4 -> pattern 0,1,1,1.
5. Clear en at cnt=1 of period=6 -> 4 more ticks complete, period_tick pulses, active drops, pwm_out goes to the pol level; en=1 with period=0 -> stays IDLE.
6. Assert reset_n low mid-high-pulse, asynchronously between clk edges -> pwm_out, active, and period_tick go to 0 immediately; after release with en still set, RUN restarts with cnt=0.
